// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for async-FIFO pointer logic: Gray conversions and
// synchronizer depth limits. Functions work on 32-bit vectors; callers
// zero-extend and truncate to their pointer width.
package cdc_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs keep the upper bits zero, so the fold is exact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus. Plain flop chain, no logic
// between stages, so it can be reused in either crossing direction.
module cdc_sync_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the incoming bus one stage per clock; clear asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= {stage_q[STAGES-2:0], d_i};
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_r2w_full_ctrl.sv
// Write-side control of an async FIFO: synchronizes the read Gray pointer,
// advances the write pointer, and produces level/full/almost-full plus
// sticky overflow and pointer-corruption flags. All status is pessimistic:
// reads only become visible after the synchronizer latency.
module sync_r2w_full_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  W_CLK,
  input  logic                  W_rst_n,
  input  logic [ADDR_WIDTH:0]   R_ptr,
  input  logic                  W_inc,
  output logic                  W_wen,
  output logic [ADDR_WIDTH-1:0] W_addr,
  output logic [ADDR_WIDTH:0]   W_ptr,
  output logic [ADDR_WIDTH:0]   Wq_rptr,
  output logic [ADDR_WIDTH:0]   W_level,
  output logic                  W_full,
  output logic                  W_almost_full,
  output logic                  W_overflow,
  output logic                  W_ptr_err
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $fatal(1, "SYNC_STAGES must be in 2..4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "AF_LEVEL must be in 1..DEPTH");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  cdc_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (W_CLK),
    .rst_ni (W_rst_n),
    .d_i    (R_ptr),
    .q_o    (Wq_rptr)
  );

  // Writes are dropped while full; the reset term keeps memory quiet in reset.
  assign W_wen = W_inc & ~full_q & W_rst_n;

  // Next-state: pointer advance, modular occupancy and status flags.
  always_comb begin
    wbin_d  = wbin_q + PW'(W_wen);
    wptr_d  = PW'(bin2gray(32'(wbin_d)));
    rbin    = PW'(gray2bin(32'(Wq_rptr)));
    level_d = wbin_d - rbin;
    full_d  = (level_d == DEPTH_C);
    af_d    = (level_d >= AF_C);
    ovf_d   = ovf_q | (W_inc & full_q);
    // Occupancy beyond DEPTH is only reachable with a non-Gray read pointer.
    err_d   = err_q | (level_d > DEPTH_C);
  end

  // Write-side state registers.
  always_ff @(posedge W_CLK or negedge W_rst_n) begin
    if (!W_rst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign W_addr        = wbin_q[ADDR_WIDTH-1:0];
  assign W_ptr         = wptr_q;
  assign W_level       = level_q;
  assign W_full        = full_q;
  assign W_almost_full = af_q;
  assign W_overflow    = ovf_q;
  assign W_ptr_err     = err_q;

endmodule

// File: tb/tb_sync_r2w_full_ctrl.sv
// Directed bench for the write-side FIFO control. A second instance with a
// three-stage synchronizer shares stimulus to check the extra drain latency.
module tb_sync_r2w_full_ctrl;

  logic       W_CLK = 1'b0;
  logic       W_rst_n;
  logic [4:0] R_ptr;
  logic       W_inc;

  logic       W_wen, W_full, W_almost_full, W_overflow, W_ptr_err;
  logic [3:0] W_addr;
  logic [4:0] W_ptr, Wq_rptr, W_level;

  logic       d3_wen, d3_full, d3_af, d3_ovf, d3_err;
  logic [3:0] d3_addr;
  logic [4:0] d3_ptr, d3_rq, d3_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 W_CLK = ~W_CLK;

  sync_r2w_full_ctrl u_dut (
    .W_CLK(W_CLK), .W_rst_n(W_rst_n), .R_ptr(R_ptr), .W_inc(W_inc),
    .W_wen(W_wen), .W_addr(W_addr), .W_ptr(W_ptr), .Wq_rptr(Wq_rptr),
    .W_level(W_level), .W_full(W_full), .W_almost_full(W_almost_full),
    .W_overflow(W_overflow), .W_ptr_err(W_ptr_err)
  );

  sync_r2w_full_ctrl #(.SYNC_STAGES(3)) u_dut3 (
    .W_CLK(W_CLK), .W_rst_n(W_rst_n), .R_ptr(R_ptr), .W_inc(W_inc),
    .W_wen(d3_wen), .W_addr(d3_addr), .W_ptr(d3_ptr), .Wq_rptr(d3_rq),
    .W_level(d3_level), .W_full(d3_full), .W_almost_full(d3_af),
    .W_overflow(d3_ovf), .W_ptr_err(d3_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge.
  task automatic step();
    @(posedge W_CLK);
    #1;
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Reset with the given read pointer; release 1 time unit after an edge.
  task automatic do_reset(input logic [4:0] rp);
    W_inc   = 1'b0;
    R_ptr   = rp;
    W_rst_n = 1'b0;
    step();
    step();
    W_rst_n = 1'b1;
  endtask

  int max_lvl;

  initial begin
    W_rst_n = 1'b0;
    W_inc   = 1'b0;
    R_ptr   = 5'b10101;

    // Reset state, with a write request held to prove W_wen stays low.
    #2;
    W_inc = 1'b1;
    step();
    step();
    #0;
    chk("rst_wen",   32'(W_wen), 0);
    chk("rst_rq",    32'(Wq_rptr), 0);
    chk("rst_ptr",   32'(W_ptr), 0);
    chk("rst_level", 32'(W_level), 0);
    chk("rst_flags", {28'd0, W_full, W_almost_full, W_overflow, W_ptr_err}, 0);
    W_inc   = 1'b0;
    W_rst_n = 1'b1;
    step();
    chk("sync_edge1", 32'(Wq_rptr), 0);
    step();
    chk("sync_edge2", 32'(Wq_rptr), 32'h15);

    // Fill from empty: almost-full after write 14, full after write 16.
    do_reset(5'd0);
    W_inc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 13) chk("af_w13", 32'(W_almost_full), 0);
      if (k == 14) chk("af_w14", 32'(W_almost_full), 1);
      if (k == 15) chk("full_w15", 32'(W_full), 0);
    end
    chk("full_w16",  32'(W_full), 1);
    chk("level_w16", 32'(W_level), 16);
    chk("wptr_w16",  32'(W_ptr), 32'h18);
    chk("d3_full",   32'(d3_full), 1);

    // Overflow: request while full is dropped and latched.
    #0;
    chk("ovf_wen",  32'(W_wen), 0);
    chk("ovf_addr", 32'(W_addr), 0);
    step();
    chk("ovf_set",   32'(W_overflow), 1);
    chk("ovf_addr2", 32'(W_addr), 0);
    chk("ovf_level", 32'(W_level), 16);
    W_inc = 1'b0;
    step();
    step();
    chk("ovf_sticky", 32'(W_overflow), 1);

    // Drain latency: one read becomes visible SYNC_STAGES+1 edges later.
    R_ptr = gray(1);
    step();
    step();
    chk("drain_e2",    32'(W_full), 1);
    step();
    chk("drain_e3",    32'(W_full), 0);
    chk("drain_lvl",   32'(W_level), 15);
    chk("drain_d3_e3", 32'(d3_full), 1);
    step();
    chk("drain_d3_e4", 32'(d3_full), 0);

    // Wrap: 40 writes with the read pointer trailing by four.
    do_reset(5'd0);
    max_lvl = 0;
    W_inc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      R_ptr = gray((i >= 4) ? (i - 4) : 0);
      step();
      if (int'(W_level) > max_lvl) max_lvl = int'(W_level);
    end
    W_inc = 1'b0;
    chk("wrap_maxlvl", 32'(max_lvl > 16), 0);
    chk("wrap_err",    32'(W_ptr_err), 0);
    chk("wrap_addr",   32'(W_addr), 8);
    chk("wrap_wptr",   32'(W_ptr), 32'h0C);
    R_ptr = gray(40);
    for (int i = 0; i < 4; i++) step();
    chk("wrap_empty",  32'(W_level), 0);

    // Corruption: wbin=2, read pointer jumps to gray(10) -> level 24 > 16.
    do_reset(5'd0);
    W_inc = 1'b1;
    step();
    step();
    W_inc = 1'b0;
    R_ptr = gray(10);
    step();
    step();
    chk("err_e2",   32'(W_ptr_err), 0);
    step();
    chk("err_e3",   32'(W_ptr_err), 1);
    chk("err_addr", 32'(W_addr), 2);
    R_ptr = gray(2);
    for (int i = 0; i < 4; i++) step();
    chk("err_sticky", 32'(W_ptr_err), 1);
    W_rst_n = 1'b0;
    #1;
    chk("err_rst", 32'(W_ptr_err), 0);
    step();
    W_rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
